// File: rtl/fq_sweep_ctrl.sv
// Frequency sweep sequencer: steps a divider's count from a start to a stop value,
// holding each count for a programmed number of divided-clock rising edges.
module fq_sweep_ctrl #(
  parameter int CNT_LEN  = 8,
  parameter int HOLD_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_LEN-1:0]  cnt_start,
  input  logic [CNT_LEN-1:0]  cnt_stop,
  input  logic [CNT_LEN-1:0]  cnt_step,
  input  logic [HOLD_LEN-1:0] hold,
  input  logic                fq_clk,
  output logic [CNT_LEN-1:0]  cnt_out,
  output logic                fq_rst,
  output logic                busy,
  output logic                step_strobe,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    FINISH
  } state_t;

  state_t              state_q;
  logic [CNT_LEN-1:0]  cntOut_q;
  logic [CNT_LEN-1:0]  stop_q;
  logic [CNT_LEN-1:0]  cntStep_q;
  logic [HOLD_LEN-1:0] hold_q;
  logic [HOLD_LEN-1:0] periodCnt_q;
  logic                fqRst_q;
  logic                busy_q;
  logic                stepStrobe_q;
  logic                done_q;
  logic                err_q;
  logic                syncS1_q;
  logic                syncS2_q;

  logic                rise_d;
  logic                cfgValid_d;
  logic [CNT_LEN:0]    nxtCnt_d;
  logic                stepOk_d;
  logic [HOLD_LEN-1:0] periodCnt_d;
  logic                holdHit_d;

  // The extra top bit of nxtCnt_d catches wrap-around past the count width.
  always_comb begin
    rise_d      = syncS1_q & ~syncS2_q;
    cfgValid_d  = (cnt_step != '0) && (hold != '0) && (cnt_start <= cnt_stop);
    nxtCnt_d    = {1'b0, cntOut_q} + {1'b0, cntStep_q};
    stepOk_d    = !nxtCnt_d[CNT_LEN] && (nxtCnt_d[CNT_LEN-1:0] <= stop_q);
    periodCnt_d = periodCnt_q + HOLD_LEN'(1);
    holdHit_d   = (periodCnt_d == hold_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cntOut_q     <= '0;
      stop_q       <= '0;
      cntStep_q    <= '0;
      hold_q       <= '0;
      periodCnt_q  <= '0;
      fqRst_q      <= 1'b1;
      busy_q       <= 1'b0;
      stepStrobe_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      syncS1_q     <= 1'b0;
      syncS2_q     <= 1'b0;
    end else begin
      syncS1_q     <= fq_clk;
      syncS2_q     <= syncS1_q;
      stepStrobe_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;

      case (state_q)
        IDLE: begin
          fqRst_q <= 1'b1;
          busy_q  <= 1'b0;
          if (start) begin
            if (cfgValid_d) begin
              stop_q      <= cnt_stop;
              cntStep_q   <= cnt_step;
              hold_q      <= hold;
              cntOut_q    <= cnt_start;
              periodCnt_q <= '0;
              busy_q      <= 1'b1;
              state_q     <= ARM;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        // Rises seen while the divider is still held in reset are simply dropped.
        ARM: begin
          if (abort) begin
            busy_q  <= 1'b0;
            fqRst_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            fqRst_q <= 1'b0;
            state_q <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            fqRst_q <= 1'b1;
            state_q <= IDLE;
          end else if (rise_d) begin
            if (holdHit_d) begin
              periodCnt_q <= '0;
              if (stepOk_d) begin
                cntOut_q     <= nxtCnt_d[CNT_LEN-1:0];
                stepStrobe_q <= 1'b1;
              end else begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                fqRst_q <= 1'b1;
                state_q <= FINISH;
              end
            end else begin
              periodCnt_q <= periodCnt_d;
            end
          end
        end

        FINISH: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cnt_out     = cntOut_q;
  assign fq_rst      = fqRst_q;
  assign busy        = busy_q;
  assign step_strobe = stepStrobe_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
